// File: rtl/renkon_net_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : renkon_net_loader_if
// Brief    : Launch, source-memory, net-memory and req/ack bundle of the loader.
//            src_ready exists only when RENKON_LOADER_STALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface renkon_net_loader_if #(
    parameter int RENKON_CORELOG = 3,
    parameter int RENKON_NETSIZE = 11,
    parameter int DWIDTH         = 16,
    parameter int MEMSIZE        = 12
);
    logic                        start;
    logic [MEMSIZE-1:0]          src_base;
    logic [RENKON_CORELOG:0]     n_cores;
    logic [RENKON_NETSIZE:0]     words;
    logic [RENKON_NETSIZE-1:0]   net_offset;
    logic                        src_re;
    logic [MEMSIZE-1:0]          src_addr;
    logic signed [DWIDTH-1:0]    src_rdata;
`ifdef RENKON_LOADER_STALL_EN
    logic                        src_ready;
`endif
    logic [RENKON_CORELOG-1:0]   net_sel;
    logic                        net_we;
    logic [RENKON_NETSIZE-1:0]   net_addr;
    logic signed [DWIDTH-1:0]    net_wdata;
    logic                        req;
    logic                        ack;
    logic                        busy;
    logic                        done;

    modport master (
`ifdef RENKON_LOADER_STALL_EN
        input  src_ready,
`endif
        input  start, src_base, n_cores, words, net_offset, src_rdata, ack,
        output src_re, src_addr, net_sel, net_we, net_addr, net_wdata,
        output req, busy, done
    );

    modport slave (
`ifdef RENKON_LOADER_STALL_EN
        output src_ready,
`endif
        output start, src_base, n_cores, words, net_offset, src_rdata, ack,
        input  src_re, src_addr, net_sel, net_we, net_addr, net_wdata,
        input  req, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/renkon_net_loader.sv
`default_nettype none
// ============================================================================
// Module   : renkon_net_loader
// Brief    : Streams per-core weights from a source memory into the renkon net
//            memories, then runs one req/ack layer handshake.
//            Optional macro RENKON_LOADER_STALL_EN gates reads with src_ready.
// Revision : 1.0 - initial release
// ============================================================================
module renkon_net_loader #(
    parameter int RENKON_CORE    = 8,
    parameter int RENKON_CORELOG = 3,
    parameter int RENKON_NETSIZE = 11,
    parameter int DWIDTH         = 16,
    parameter int MEMSIZE        = 12
) (
    input  wire logic               clk,
    input  wire logic               rst,
    renkon_net_loader_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [RENKON_CORELOG:0] C_CORE     = (RENKON_CORELOG+1)'(RENKON_CORE);
    localparam logic [RENKON_CORELOG:0] C_CORE_ONE = (RENKON_CORELOG+1)'(1);
    localparam logic [RENKON_NETSIZE:0] C_WORD_ONE = (RENKON_NETSIZE+1)'(1);

    state_t                       r_state;
    state_t                       w_next;

    logic [MEMSIZE-1:0]           r_src_addr;
    logic [RENKON_CORELOG:0]      r_ncores;
    logic [RENKON_CORELOG:0]      r_c;
    logic [RENKON_NETSIZE:0]      r_words;
    logic [RENKON_NETSIZE:0]      r_w;
    logic [RENKON_NETSIZE-1:0]    r_offset;
    logic [RENKON_CORELOG-1:0]    r_net_sel;
    logic [RENKON_NETSIZE-1:0]    r_net_addr;
    logic signed [DWIDTH-1:0]     r_wdata;
    logic                         r_wr_pend;

    logic [RENKON_CORELOG:0]      w_ncores_clamped;
    logic                         w_launch;
    logic                         w_empty;
    logic                         w_rd;
    logic                         w_word_last;
    logic                         w_core_last;
    logic                         w_req;
    logic                         w_busy;
    logic                         w_done;

    assign w_launch         = (r_state == S_IDLE) && bus.start;
    assign w_ncores_clamped = (bus.n_cores > C_CORE) ? C_CORE : bus.n_cores;
    assign w_empty          = (bus.n_cores == '0) || (bus.words == '0);
    assign w_word_last      = (r_w == (r_words - C_WORD_ONE));
    assign w_core_last      = (r_c == (r_ncores - C_CORE_ONE));

`ifdef RENKON_LOADER_STALL_EN
    assign w_rd = (r_state == S_FETCH) && bus.src_ready;
`else
    assign w_rd = (r_state == S_FETCH);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = w_empty ? S_REQ : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_rd && w_word_last && w_core_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: w_next = S_REQ;
            S_REQ: begin
                w_req  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ack) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // The running source address equals src_base + c*words + w, since the
    // layout is core-major and contiguous.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_addr <= '0;
            r_ncores   <= '0;
            r_c        <= '0;
            r_words    <= '0;
            r_w        <= '0;
            r_offset   <= '0;
            r_net_sel  <= '0;
            r_net_addr <= '0;
            r_wdata    <= '0;
            r_wr_pend  <= 1'b0;
        end else begin
            r_wr_pend <= w_rd;
            if (r_wr_pend) begin
                r_wdata <= bus.src_rdata;
            end
            if (w_launch) begin
                r_src_addr <= bus.src_base;
                r_ncores   <= w_ncores_clamped;
                r_words    <= bus.words;
                r_offset   <= bus.net_offset;
                r_c        <= '0;
                r_w        <= '0;
            end else if (w_rd) begin
                r_src_addr <= r_src_addr + MEMSIZE'(1);
                r_net_sel  <= r_c[RENKON_CORELOG-1:0];
                r_net_addr <= r_offset + r_w[RENKON_NETSIZE-1:0];
                if (w_word_last) begin
                    r_w <= '0;
                    r_c <= r_c + C_CORE_ONE;
                end else begin
                    r_w <= r_w + C_WORD_ONE;
                end
            end
        end
    end

    assign bus.src_re    = w_rd;
    assign bus.src_addr  = r_src_addr;
    assign bus.net_we    = r_wr_pend;
    assign bus.net_sel   = r_net_sel;
    assign bus.net_addr  = r_net_addr;
    // Read data arrives the cycle after src_re, so it passes straight through
    // on a write and is held in r_wdata otherwise.
    assign bus.net_wdata = r_wr_pend ? bus.src_rdata : r_wdata;
    assign bus.req       = w_req;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_renkon_net_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_renkon_net_loader
// Brief    : Scoreboard bench for renkon_net_loader (reads, writes, handshake).
// Revision : 1.0 - initial release
// ============================================================================
module tb_renkon_net_loader;
    localparam int CL = 3;
    localparam int NS = 11;
    localparam int DW = 16;
    localparam int MS = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    renkon_net_loader_if #(.RENKON_CORELOG(CL), .RENKON_NETSIZE(NS),
                           .DWIDTH(DW), .MEMSIZE(MS)) bus ();

    renkon_net_loader #(.RENKON_CORE(8), .RENKON_CORELOG(CL), .RENKON_NETSIZE(NS),
                        .DWIDTH(DW), .MEMSIZE(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [CL+NS+DW-1:0] exp_wr[$];
    logic [MS-1:0]       exp_rd[$];

    // Source memory holds mem[a] = a, one-cycle read latency
    always @(posedge clk) begin
        if (bus.src_re) bus.src_rdata <= DW'(bus.src_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.src_re) begin
                if (exp_rd.size() == 0) check("unexpected src_re", 64'(bus.src_re), 64'd0);
                else check("src_addr", 64'(bus.src_addr), 64'(exp_rd.pop_front()));
            end
            if (bus.net_we) begin
                wr_cnt++;
                if (exp_wr.size() == 0) check("unexpected net_we", 64'(bus.net_we), 64'd0);
                else check("net write {sel,addr,data}",
                           64'({bus.net_sel, bus.net_addr, bus.net_wdata}),
                           64'(exp_wr.pop_front()));
            end
        end
    end

    task automatic push_wr(input int sel, input int addr, input int data);
        exp_wr.push_back({CL'(sel), NS'(addr), DW'(data)});
    endtask

    task automatic model(input int base, input int nc, input int wds, input int off);
        int ncm;
        ncm = (nc > 8) ? 8 : nc;
        for (int c = 0; c < ncm; c++) begin
            for (int w = 0; w < wds; w++) begin
                exp_rd.push_back(MS'((base + c * wds + w) % 4096));
                push_wr(c, (off + w) % 2048, (base + c * wds + w) % 4096);
            end
        end
    endtask

    // Start is sampled at the posedge after it is raised; inputs are then
    // scrambled to show the job runs on latched values.
    task automatic launch(input int base, input int nc, input int wds, input int off);
        wr_cnt = 0;
        @(posedge clk); #1;
        bus.src_base   = MS'(base);
        bus.n_cores    = (CL+1)'(nc);
        bus.words      = (NS+1)'(wds);
        bus.net_offset = NS'(off);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.src_base   = ~bus.src_base;
        bus.n_cores    = (CL+1)'(1);
        bus.words      = (NS+1)'(1);
        bus.net_offset = ~bus.net_offset;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req && n < 300);
        check("req seen", 64'(bus.req), 64'd1);
    endtask

    task automatic handshake(input int hold);
        logic ok;
        ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.busy || bus.req || bus.done) ok = 1'b0;
        end
        check("busy held while waiting for ack", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.ack = 1'b1;
        @(negedge clk);
        check("ack cycle {done,busy}", 64'({bus.done, bus.busy}), 64'b01);
        @(posedge clk); #1;
        bus.ack = 1'b0;
        @(negedge clk);
        check("done cycle {done,busy}", 64'({bus.done, bus.busy}), 64'b10);
        @(negedge clk);
        check("after done {done,busy}", 64'({bus.done, bus.busy}), 64'b00);
    endtask

    task automatic job_end(input string name, input int writes);
        check({name, " write count"}, 64'(wr_cnt), 64'(writes));
        check({name, " queues drained"}, 64'(exp_wr.size() + exp_rd.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.src_re, bus.src_addr, bus.net_we, bus.net_sel, bus.net_addr,
                    bus.net_wdata, bus.req, bus.busy, bus.done});
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.ack = 1'b0;
        bus.src_base = '0; bus.n_cores = '0; bus.words = '0; bus.net_offset = '0;
`ifdef RENKON_LOADER_STALL_EN
        bus.src_ready = 1'b1;
`endif
        repeat (2) @(negedge clk);
        check("reset outputs", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic load with literal expectations
        for (int i = 0; i < 6; i++) exp_rd.push_back(MS'(12'h010 + i));
        push_wr(0, 4, 'h10); push_wr(0, 5, 'h11); push_wr(0, 6, 'h12);
        push_wr(1, 4, 'h13); push_wr(1, 5, 'h14); push_wr(1, 6, 'h15);
        launch('h010, 2, 3, 'h004);
        @(negedge clk);
        check("first cycle {src_re,net_we}", 64'({bus.src_re, bus.net_we}), 64'b10);
        @(negedge clk);
        check("first write two cycles after start", 64'(bus.net_we), 64'd1);
        wait_req();
        handshake(20);
        job_end("basic", 6);

        // words = 0, with ack raised during the REQ cycle (must be ignored)
        launch('h123, 3, 0, 'h010);
        @(negedge clk);
        check("words=0 {req,busy}", 64'({bus.req, bus.busy}), 64'b11);
        bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        @(negedge clk);
        check("ack in REQ ignored {done,busy}", 64'({bus.done, bus.busy}), 64'b01);
        handshake(2);
        job_end("words=0", 0);

        // n_cores = 0
        launch('h000, 0, 5, 'h000);
        @(negedge clk);
        check("n_cores=0 req", 64'(bus.req), 64'd1);
        handshake(0);
        job_end("n_cores=0", 0);

        // Clamp 15 -> 8 cores
        model('h200, 15, 2, 'h100);
        launch('h200, 15, 2, 'h100);
        wait_req();
        handshake(1);
        job_end("clamp", 16);

        // Wraparound of both address spaces
        exp_rd.push_back(12'hFFE); exp_rd.push_back(12'hFFF);
        exp_rd.push_back(12'h000); exp_rd.push_back(12'h001);
        push_wr(0, 'h7FE, 'hFFE); push_wr(0, 'h7FF, 'hFFF);
        push_wr(0, 'h000, 'h000); push_wr(0, 'h001, 'h001);
        launch('hFFE, 1, 4, 'h7FE);
        wait_req();
        handshake(1);
        job_end("wrap", 4);

        // Start pulsed mid-FETCH with different inputs
        model('h100, 2, 5, 'h020);
        launch('h100, 2, 5, 'h020);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.words = (NS+1)'(7); bus.n_cores = (CL+1)'(1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_req();
        handshake(1);
        job_end("start abuse", 10);

        // Reset while waiting for ack, then a clean job
        model('h300, 1, 2, 'h000);
        launch('h300, 1, 2, 'h000);
        wait_req();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("outputs after reset in WAIT", all_outs(), 64'd0);
        model('h020, 1, 3, 'h040);
        launch('h020, 1, 3, 'h040);
        wait_req();
        handshake(1);
        job_end("after reset", 3);

`ifdef RENKON_LOADER_STALL_EN
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            model('h050, 1, 4, 'h008);
            launch('h050, 1, 4, 'h008);
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                check("stall src_re", 64'(bus.src_re), 64'(pat[i]));
                if (i > 0) check("stall net_we", 64'(bus.net_we), 64'(pat[i-1]));
                @(posedge clk); #1;
                bus.src_ready = (i < 6) ? pat[i+1] : 1'b1;
            end
            @(negedge clk);
            check("stall last net_we", 64'({bus.net_we, bus.src_re}), 64'b10);
            wait_req();
            handshake(1);
            job_end("stall", 4);
        end
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
